counter_arb_ctrl: RTL and testbench

COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

---
 rtl/counter_arb_ctrl.sv | 79 +++++++
 tb/tb_counter_arb_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_arb_ctrl.sv
// counter_arb_ctrl: arbitrates two requesters for a shared up/down counter and sequences load, count and done.
// Define COUNTER_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module counter_arb_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [1:0]        req,
    input  logic [7:0]        start0,
    input  logic [7:0]        start1,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    input  logic              dir0,
    input  logic              dir1,
    input  logic              hold,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy,
    output logic              cnt_load,
    output logic [7:0]        cnt_data,
    output logic              cnt_enable,
    output logic              cnt_dir
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
    logic [1:0]        state;
    logic [1:0]        owner;
    logic [7:0]        start_q;
    logic [STEP_W-1:0] rem;
    logic              dir_q;
    logic              pick;
`ifdef COUNTER_ARB_RR_EN
    logic              ptr;
    // ptr high means requester 1 is favoured on a tie
    assign pick = req[1] & (~req[0] | ptr);
`else
    assign pick = ~req[0];
`endif
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state   <= IDLE;
            owner   <= 2'b00;
            start_q <= 8'h00;
            rem     <= '0;
            dir_q   <= 1'b0;
`ifdef COUNTER_ARB_RR_EN
            ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state   <= LOAD;
                    owner   <= pick ? 2'b10 : 2'b01;
                    start_q <= pick ? start1 : start0;
                    rem     <= pick ? steps1 : steps0;
                    dir_q   <= pick ? dir1 : dir0;
                end
                LOAD: state <= (rem == '0) ? DONE : RUN;
                RUN: if (!hold) begin
                    rem <= rem - 1'b1;
                    if (rem == STEP_W'(1)) state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'b00;
                    dir_q <= 1'b0;
`ifdef COUNTER_ARB_RR_EN
                    ptr   <= owner[0];
`endif
                end
            endcase
        end
    assign gnt        = owner;
    assign done       = (state == DONE) ? owner : 2'b00;
    assign busy       = state != IDLE;
    assign cnt_load   = state == LOAD;
    assign cnt_data   = cnt_load ? start_q : 8'h00;
    assign cnt_enable = (state == RUN) && !hold;
    assign cnt_dir    = busy & dir_q;
endmodule

// File: tb/tb_counter_arb_ctrl.sv
// tb_counter_arb_ctrl: directed job vectors, corner sequences and a random run against a job-level model.
module tb_counter_arb_ctrl;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] start0 = 8'h00, start1 = 8'h00, steps0 = 8'h00, steps1 = 8'h00;
    logic       dir0 = 1'b0, dir1 = 1'b0, hold = 1'b0;
    logic [1:0] gnt, done;
    logic       busy, cnt_load, cnt_enable, cnt_dir;
    logic [7:0] cnt_data;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    counter_arb_ctrl #(.STEP_W(8)) dut (
        .clk(clk), .clr(clr), .req(req), .start0(start0), .start1(start1),
        .steps0(steps0), .steps1(steps1), .dir0(dir0), .dir1(dir1), .hold(hold),
        .gnt(gnt), .done(done), .busy(busy), .cnt_load(cnt_load), .cnt_data(cnt_data),
        .cnt_enable(cnt_enable), .cnt_dir(cnt_dir)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] s0, s1, n0, n1;
        logic       d0, d1;
        logic [1:0] g;
        logic [7:0] data;
        int         en;
        logic       dir;
    } vec_t;
    vec_t v[5];

    function automatic logic [15:0] outs();
        return {gnt, done, busy, cnt_load, cnt_data, cnt_enable, cnt_dir};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one job from IDLE, scrambles the job inputs after the grant, and observes it to completion.
    task automatic run_job(input logic [1:0] r, input int hold_at, input int hold_len,
                           output logic [1:0] g, output logic [7:0] data, output logic d,
                           output int en, output int lat, output logic [1:0] dn, output logic bad);
        int hl;
        hl = 0; g = 0; data = 0; d = 0; en = 0; lat = -1; dn = 0; bad = 0;
        req = r;
        @(posedge clk); @(negedge clk);
        req = 2'b00; start0 = ~start0; start1 = ~start1;
        steps0 = steps0 + 8'd3; steps1 = steps1 + 8'd3; dir0 = ~dir0; dir1 = ~dir1;
        for (int c = 0; c < 300; c++) begin
            hold = hl > 0;
            if (hl > 0) hl--;
            #1;
            if (c == 0) begin
                g = gnt; data = cnt_data; d = cnt_dir; bad = !cnt_load;
            end else if (cnt_load || cnt_dir !== d || gnt !== g) bad = 1;
            if (cnt_enable) begin
                en++;
                if (en == hold_at) hl = hold_len;
            end
            if (done != 2'b00) begin
                dn = done; lat = c;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        hold = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        if (busy || gnt != 2'b00 || cnt_dir || done != 2'b00) bad = 1;
    endtask

    logic [1:0] g, dn, gx;
    logic [7:0] data;
    logic       d, bad;
    int         en, lat;
    logic       m_act, m_loaded, m_dir;
    int         m_who, m_last, m_left;
    logic [7:0] m_start;
    logic [15:0] exp_o;

    initial begin
        v[0] = '{2'b01, 8'h10, 8'h00, 8'd3, 8'd0, 1'b0, 1'b0, 2'b01, 8'h10, 3, 1'b0};
        v[1] = '{2'b10, 8'h00, 8'hA5, 8'd0, 8'd0, 1'b0, 1'b0, 2'b10, 8'hA5, 0, 1'b0};
        v[2] = '{2'b10, 8'h77, 8'h00, 8'd5, 8'd2, 1'b0, 1'b1, 2'b10, 8'h00, 2, 1'b1};
        v[3] = '{2'b01, 8'hFF, 8'h12, 8'd1, 8'd4, 1'b1, 1'b0, 2'b01, 8'hFF, 1, 1'b1};
        v[4] = '{2'b10, 8'h01, 8'h3C, 8'd2, 8'd7, 1'b1, 1'b0, 2'b10, 8'h3C, 7, 1'b0};
        @(negedge clk); @(negedge clk); #1;
        check("reset_outputs", outs(), 16'h0000);
        clr = 1'b0;
        @(negedge clk);

        foreach (v[i]) begin
            start0 = v[i].s0; start1 = v[i].s1; steps0 = v[i].n0; steps1 = v[i].n1;
            dir0 = v[i].d0; dir1 = v[i].d1;
            run_job(v[i].req, -1, 0, g, data, d, en, lat, dn, bad);
            check($sformatf("vec%0d_gnt", i), g, v[i].g);
            check($sformatf("vec%0d_data", i), data, v[i].data);
            check($sformatf("vec%0d_enables", i), en, v[i].en);
            check($sformatf("vec%0d_dir", i), d, v[i].dir);
            check($sformatf("vec%0d_done", i), dn, v[i].g);
            check($sformatf("vec%0d_latency", i), lat, v[i].en + 1);
            check($sformatf("vec%0d_protocol", i), bad, 1'b0);
        end

        start0 = 8'h20; steps0 = 8'd4; dir0 = 1'b0;
        run_job(2'b01, 2, 2, g, data, d, en, lat, dn, bad);
        check("hold_enables", en, 4);
        check("hold_latency", lat, 7);
        check("hold_protocol", bad, 1'b0);

        clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
        for (int k = 0; k < 3; k++) begin
`ifdef COUNTER_ARB_RR_EN
            gx = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            gx = 2'b01;
`endif
            steps0 = 8'd1; steps1 = 8'd1;
            run_job(2'b11, -1, 0, g, data, d, en, lat, dn, bad);
            check($sformatf("tie%0d_gnt", k), g, gx);
            check($sformatf("tie%0d_enables", k), en, 1);
        end

        start0 = 8'h33; steps0 = 8'd5; dir0 = 1'b1;
        req = 2'b01;
        @(posedge clk); @(negedge clk);
        req = 2'b00; en = 0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (cnt_enable) en++;
            dn = dn | done;
            if (en == 2) break;
            @(posedge clk); @(negedge clk);
        end
        check("abort_enables_seen", en, 2);
        @(posedge clk); #2;
        clr = 1'b1; #1;
        check("abort_outputs", outs(), 16'h0000);
        check("abort_no_done", dn, 2'b00);
        @(negedge clk); clr = 1'b0;
        start0 = 8'h44; steps0 = 8'd2; dir0 = 1'b0;
        run_job(2'b01, -1, 0, g, data, d, en, lat, dn, bad);
        check("after_abort_gnt", g, 2'b01);
        check("after_abort_data", data, 8'h44);
        check("after_abort_enables", en, 2);

        clr = 1'b1; @(negedge clk); clr = 1'b0;
        m_act = 0; m_loaded = 0; m_who = 0; m_last = 1; m_left = 0; m_start = 0; m_dir = 0;
        for (int i = 0; i < 3000; i++) begin
            req = 2'($urandom_range(0, 3));
            start0 = 8'($urandom); start1 = 8'($urandom);
            steps0 = 8'($urandom_range(0, 5)); steps1 = 8'($urandom_range(0, 5));
            dir0 = 1'($urandom); dir1 = 1'($urandom);
            hold = $urandom_range(0, 3) == 0;
            clr = $urandom_range(0, 149) == 0;
            if (clr) begin
                m_act = 0; m_last = 1;
            end
            #1;
            exp_o = 16'h0000;
            if (m_act) begin
                gx = (m_who == 1) ? 2'b10 : 2'b01;
                if (!m_loaded) exp_o = {gx, 2'b00, 1'b1, 1'b1, m_start, 1'b0, m_dir};
                else if (m_left > 0) exp_o = {gx, 2'b00, 1'b1, 1'b0, 8'h00, !hold, m_dir};
                else exp_o = {gx, gx, 1'b1, 1'b0, 8'h00, 1'b0, m_dir};
            end
            check($sformatf("rand%0d", i), outs(), exp_o);
            @(posedge clk);
            if (!clr) begin
                if (!m_act) begin
                    if (req != 2'b00) begin
`ifdef COUNTER_ARB_RR_EN
                        m_who = (req == 2'b11) ? 1 - m_last : (req == 2'b10 ? 1 : 0);
`else
                        m_who = (req == 2'b10) ? 1 : 0;
`endif
                        m_start = (m_who == 1) ? start1 : start0;
                        m_left = (m_who == 1) ? int'(steps1) : int'(steps0);
                        m_dir = (m_who == 1) ? dir1 : dir0;
                        m_act = 1; m_loaded = 0;
                    end
                end else if (!m_loaded) m_loaded = 1;
                else if (m_left > 0) begin
                    if (!hold) m_left--;
                end else begin
                    m_act = 0; m_last = m_who;
                end
            end
            @(negedge clk);
        end
        clr = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
